// File: rtl/keyboard_matrix.sv
// PET keyboard matrix store with a configurable geometry.
// The host bridge writes per-column row state (active-low). The emulated PIA
// selects a column and reads its row byte through a registered port.
// Each column has a minimum-hold counter: once a key is pressed, releases in
// that column stay invisible until the column has been scanned HOLD_SCANS
// times. This lets a quick tap survive until the ROM scan loop has seen it.
//
// Timing seen from the ports:
//   write -> host store (edge 1) -> effective matrix (edge 2) -> row_o / any_key_o (edge 3)
//   col_sel_i -> row_o one edge later; scan_en_i only advances the hold counters.
// clear_i has priority over a write and a scan in the same cycle.
module keyboard_matrix #(
    parameter int COLS       = 10,
    parameter int ROWS       = 8,
    parameter int COL_WIDTH  = 4,
    parameter int HOLD_SCANS = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           wr_en_i,
    input  logic [COL_WIDTH-1:0]           wr_col_i,
    input  logic [ROWS-1:0]                wr_data_i,
    input  logic                           clear_i,
    input  logic                           scan_en_i,
    input  logic [COL_WIDTH-1:0]           col_sel_i,
    output logic [ROWS-1:0]                row_o,
    output logic [COLS-1:0][ROWS-1:0]      matrix_o,
    output logic                           any_key_o
);

    logic [COLS-1:0][ROWS-1:0] r_host;
    logic [COLS-1:0][ROWS-1:0] r_eff;
    logic [ROWS-1:0]           r_row;
    logic                      r_any;

    logic [COLS-1:0]           w_wr_hit;
    logic [COLS-1:0]           w_press;
    logic [COLS-1:0]           w_pass;
    logic [ROWS-1:0]           w_row;

    // Decode host writes per column; a press is any bit going from 1 to 0.
    always_comb begin
        w_wr_hit = '0;
        w_press  = '0;
        for (int c = 0; c < COLS; c++) begin
            w_wr_hit[c] = wr_en_i && (wr_col_i == COL_WIDTH'(c));
            w_press[c]  = w_wr_hit[c] && (|(r_host[c] & ~wr_data_i));
        end
    end

    // Read mux; unmatched (out-of-range) selects read as all keys released.
    always_comb begin
        w_row = '1;
        for (int c = 0; c < COLS; c++) begin
            if (col_sel_i == COL_WIDTH'(c)) begin
                w_row = r_eff[c];
            end
        end
    end

    generate
        if (HOLD_SCANS > 0) begin : g_hold
            localparam int CNT_W = $clog2(HOLD_SCANS + 1);
            localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_SCANS);

            logic [COLS-1:0][CNT_W-1:0] r_cnt;
            logic [COLS-1:0]            w_scan_hit;

            // A column passes host state straight through once its counter saturates.
            always_comb begin
                w_scan_hit = '0;
                w_pass     = '0;
                for (int c = 0; c < COLS; c++) begin
                    w_scan_hit[c] = scan_en_i && (col_sel_i == COL_WIDTH'(c));
                    w_pass[c]     = (r_cnt[c] >= HOLD_C);
                end
            end

            // Scan counters: clear saturates, a press restarts, a scan counts up.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int c = 0; c < COLS; c++) begin
                        r_cnt[c] <= HOLD_C;
                    end
                end else if (clear_i) begin
                    for (int c = 0; c < COLS; c++) begin
                        r_cnt[c] <= HOLD_C;
                    end
                end else begin
                    for (int c = 0; c < COLS; c++) begin
                        if (w_press[c]) begin
                            r_cnt[c] <= '0;
                        end else if (w_scan_hit[c] && (r_cnt[c] < HOLD_C)) begin
                            r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                        end
                    end
                end
            end
        end else begin : g_nohold
            // Without a hold window every release is visible at once.
            logic w_unused_scan;
            assign w_unused_scan = scan_en_i ^ (|w_press);
            assign w_pass        = '1;
        end
    endgenerate

    // Host-side store of the last written row state per column.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_host <= '1;
        end else if (clear_i) begin
            r_host <= '1;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (w_wr_hit[c]) begin
                    r_host[c] <= wr_data_i;
                end
            end
        end
    end

    // Effective matrix: follow host when unheld, otherwise only accept presses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_eff <= '1;
        end else if (clear_i) begin
            r_eff <= '1;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (w_pass[c]) begin
                    r_eff[c] <= r_host[c];
                end else begin
                    r_eff[c] <= r_eff[c] & r_host[c];
                end
            end
        end
    end

    // Registered read port and any-key flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_row <= '1;
            r_any <= 1'b0;
        end else begin
            r_row <= w_row;
            r_any <= ~(&r_eff);
        end
    end

    assign row_o     = r_row;
    assign matrix_o  = r_eff;
    assign any_key_o = r_any;

endmodule

// File: tb/tb_keyboard_matrix.sv
// Bench for keyboard_matrix: instance A uses the default 10x8 geometry with a
// two-scan hold; instance B is 16x8 with no hold. Stimulus pushes expected
// values into a queue right after an edge; a monitor pops and compares them
// on the following falling edge.
module tb_keyboard_matrix;

    logic clk;
    logic rst_n;

    // Instance A inputs/outputs
    logic                 wr_en_a;
    logic [3:0]           wr_col_a;
    logic [7:0]           wr_data_a;
    logic                 clear_a;
    logic                 scan_en_a;
    logic [3:0]           col_sel_a;
    logic [7:0]           row_a;
    logic [9:0][7:0]      matrix_a;
    logic                 any_a;

    // Instance B inputs/outputs
    logic                 wr_en_b;
    logic [3:0]           wr_col_b;
    logic [7:0]           wr_data_b;
    logic                 clear_b;
    logic                 scan_en_b;
    logic [3:0]           col_sel_b;
    logic [7:0]           row_b;
    logic [15:0][7:0]     matrix_b;
    logic                 any_b;

    keyboard_matrix #(.COLS(10), .ROWS(8), .COL_WIDTH(4), .HOLD_SCANS(2)) u_dut_a (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .wr_en_i   (wr_en_a),
        .wr_col_i  (wr_col_a),
        .wr_data_i (wr_data_a),
        .clear_i   (clear_a),
        .scan_en_i (scan_en_a),
        .col_sel_i (col_sel_a),
        .row_o     (row_a),
        .matrix_o  (matrix_a),
        .any_key_o (any_a)
    );

    keyboard_matrix #(.COLS(16), .ROWS(8), .COL_WIDTH(4), .HOLD_SCANS(0)) u_dut_b (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .wr_en_i   (wr_en_b),
        .wr_col_i  (wr_col_b),
        .wr_data_i (wr_data_b),
        .clear_i   (clear_b),
        .scan_en_i (scan_en_b),
        .col_sel_i (col_sel_b),
        .row_o     (row_b),
        .matrix_o  (matrix_b),
        .any_key_o (any_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    localparam int W = 128;
    localparam int T_ROW_A = 0, T_MAT_A = 1, T_ANY_A = 2;
    localparam int T_ROW_B = 3, T_MAT_B = 4, T_ANY_B = 5;

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_vec = 0;
    int           n_mis = 0;

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    int           mon_tag;
    string        mon_name;

    // Monitor: everything queued since the last rising edge is compared here.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            case (mon_tag)
                T_ROW_A: begin mon_act = W'(row_a);    mon_name = "row_a";    end
                T_MAT_A: begin mon_act = W'(matrix_a); mon_name = "matrix_a"; end
                T_ANY_A: begin mon_act = W'(any_a);    mon_name = "any_a";    end
                T_ROW_B: begin mon_act = W'(row_b);    mon_name = "row_b";    end
                T_MAT_B: begin mon_act = W'(matrix_b); mon_name = "matrix_b"; end
                default: begin mon_act = W'(any_b);    mon_name = "any_b";    end
            endcase
            n_vec++;
            if (mon_act !== mon_exp) begin
                n_mis++;
                $display("FAIL %s @%0t: got %h, expected %h", mon_name, $time, mon_act, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int tag, input logic [W-1:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic idle_a();
        wr_en_a   = 1'b0;
        scan_en_a = 1'b0;
        clear_a   = 1'b0;
    endtask

    // One-cycle host write on A.
    task automatic write_a(input logic [3:0] col, input logic [7:0] data);
        wr_en_a   = 1'b1;
        wr_col_a  = col;
        wr_data_a = data;
        step();
        wr_en_a   = 1'b0;
    endtask

    // One-cycle scan of a column on A (col_sel_a is left on that column).
    task automatic scan_a(input logic [3:0] col);
        scan_en_a = 1'b1;
        col_sel_a = col;
        step();
        scan_en_a = 1'b0;
    endtask

    task automatic write_b(input logic [3:0] col, input logic [7:0] data);
        wr_en_b   = 1'b1;
        wr_col_b  = col;
        wr_data_b = data;
        step();
        wr_en_b   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [9:0][7:0]  m_a;
    logic [15:0][7:0] m_b;

    initial begin
        rst_n     = 1'b0;
        wr_en_a   = 1'b0; wr_col_a = '0; wr_data_a = '1; clear_a = 1'b0;
        scan_en_a = 1'b0; col_sel_a = '0;
        wr_en_b   = 1'b0; wr_col_b = '0; wr_data_b = '1; clear_b = 1'b0;
        scan_en_b = 1'b0; col_sel_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // 1. Reset state
        m_a = '1;
        m_b = '1;
        expect_val(T_MAT_A, W'(m_a));
        expect_val(T_ANY_A, W'(1'b0));
        expect_val(T_MAT_B, W'(m_b));
        expect_val(T_ANY_B, W'(1'b0));
        for (int i = 0; i < 16; i++) begin
            col_sel_a = 4'(i);
            step();
            expect_val(T_ROW_A, W'(8'hFF));
        end

        // 2. Press col 3 = FB; row_o follows on the 3rd edge
        col_sel_a = 4'd3;
        write_a(4'd3, 8'hFB);                 // edge 1: host
        expect_val(T_MAT_A, W'(m_a));         // not yet effective
        step();                               // edge 2: effective
        m_a[3] = 8'hFB;
        expect_val(T_MAT_A, W'(m_a));
        expect_val(T_ROW_A, W'(8'hFF));
        step();                               // edge 3: row / any
        expect_val(T_ROW_A, W'(8'hFB));
        expect_val(T_ANY_A, W'(1'b1));

        // 3. Release before any scan is held for two scans of col 3
        write_a(4'd3, 8'hFF);
        step();
        step();
        expect_val(T_ROW_A, W'(8'hFB));
        scan_a(4'd4);
        scan_a(4'd4);
        col_sel_a = 4'd3;
        step();
        step();
        expect_val(T_ROW_A, W'(8'hFB));       // col 4 scans do not release col 3
        scan_a(4'd3);
        step();
        step();
        expect_val(T_ROW_A, W'(8'hFB));       // one scan is not enough
        scan_a(4'd3);                         // counter saturates on this edge
        step();                               // effective releases
        m_a[3] = 8'hFF;
        expect_val(T_MAT_A, W'(m_a));
        expect_val(T_ROW_A, W'(8'hFB));
        step();
        expect_val(T_ROW_A, W'(8'hFF));
        expect_val(T_ANY_A, W'(1'b0));

        // 4. Press write on col 5 with a same-cycle scan: press wins
        write_a(4'd5, 8'hBF);                 // cnt5 = 0
        scan_a(4'd5);                         // cnt5 = 1
        wr_en_a = 1'b1; wr_col_a = 4'd5; wr_data_a = 8'h7F;
        scan_en_a = 1'b1; col_sel_a = 4'd5;
        step();                               // cnt5 back to 0, host = 7F
        idle_a();
        write_a(4'd5, 8'hFF);                 // eff picks up 3F (BF & 7F), release held
        step();
        m_a[5] = 8'h3F;
        expect_val(T_MAT_A, W'(m_a));
        scan_a(4'd5);                         // cnt5 = 1
        step();
        expect_val(T_MAT_A, W'(m_a));
        scan_a(4'd5);                         // cnt5 = 2
        step();
        m_a[5] = 8'hFF;
        expect_val(T_MAT_A, W'(m_a));

        // 5. Out-of-range column
        write_a(4'd12, 8'h00);
        step();
        step();
        expect_val(T_MAT_A, W'(m_a));
        expect_val(T_ANY_A, W'(1'b0));
        col_sel_a = 4'd12;
        step();
        expect_val(T_ROW_A, W'(8'hFF));
        write_a(4'd7, 8'hFE);                 // press col 7
        write_a(4'd7, 8'hFF);                 // release, held
        scan_a(4'd12);
        scan_a(4'd12);
        step();
        step();
        m_a[7] = 8'hFE;
        expect_val(T_MAT_A, W'(m_a));         // col 12 scans did not advance col 7

        // 6. clear while col 0 is mid-hold; clear also beats a write and a scan
        write_a(4'd0, 8'h00);
        write_a(4'd0, 8'hFF);
        scan_a(4'd0);                         // cnt0 = 1
        step();
        m_a[0] = 8'h00;
        expect_val(T_MAT_A, W'(m_a));
        clear_a = 1'b1;
        wr_en_a = 1'b1; wr_col_a = 4'd1; wr_data_a = 8'h00;
        scan_en_a = 1'b1; col_sel_a = 4'd0;
        step();
        idle_a();
        m_a = '1;
        expect_val(T_MAT_A, W'(m_a));
        expect_val(T_ANY_A, W'(1'b1));        // still reflects pre-clear matrix
        step();
        expect_val(T_ANY_A, W'(1'b0));
        expect_val(T_MAT_A, W'(m_a));         // simultaneous write was discarded
        expect_val(T_ROW_A, W'(8'hFF));

        // 6b. Instance B: no hold, col 15 press then release
        col_sel_b = 4'd15;
        write_b(4'd15, 8'hFB);
        step();
        m_b[15] = 8'hFB;
        expect_val(T_MAT_B, W'(m_b));
        step();
        expect_val(T_ROW_B, W'(8'hFB));
        expect_val(T_ANY_B, W'(1'b1));
        write_b(4'd15, 8'hFF);                // edge 1 after release write
        expect_val(T_MAT_B, W'(m_b));
        step();                               // edge 2: release visible
        m_b[15] = 8'hFF;
        expect_val(T_MAT_B, W'(m_b));
        expect_val(T_ROW_B, W'(8'hFB));
        step();
        expect_val(T_ROW_B, W'(8'hFF));
        expect_val(T_ANY_B, W'(1'b0));

        // Let the monitor drain the queue, then report.
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, expected completion");
        $fatal(1);
    end

endmodule
